// File: rtl/shift_pkg.sv
// Shared types for the shift arbiter: opcode layout, opcode constants and result-stage states.
package shift_pkg;

    typedef struct packed {
        logic arith;
        logic leftright;
        logic logicrot;
    } opcode_t;

    localparam logic [2:0] OP_LSL = 3'b000;
    localparam logic [2:0] OP_LSR = 3'b010;
    localparam logic [2:0] OP_ASR = 3'b110;
    localparam logic [2:0] OP_ROR = 3'b011;
    localparam logic [2:0] OP_ROL = 3'b001;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } resp_state_t;

endpackage

// File: rtl/barrel_shifter.sv
// Combinational shifter/rotator; leftright=1 selects right, ASR ignores logicrot.
module barrel_shifter
    import shift_pkg::*;
#(
    parameter  int REGS_WIDTH = 32,
    localparam int AW         = $clog2(REGS_WIDTH)
) (
    input  logic [REGS_WIDTH-1:0] data,
    input  opcode_t               opsel,
    input  logic [AW-1:0]         amount,
    output logic [REGS_WIDTH-1:0] result
);

    logic [AW-1:0] amt;
    logic [2:0]    op;

    always_comb begin
        amt    = AW'(int'(amount) % REGS_WIDTH);
        op     = opsel;
        result = data;
        // A shift by REGS_WIDTH yields zero, so amt=0 rotations reduce to the identity.
        casez (op)
            3'b?00:  result = data << amt;
            3'b010:  result = data >> amt;
            3'b11?:  result = REGS_WIDTH'($signed(data) >>> amt);
            3'b011:  result = (data >> amt) | (data << (REGS_WIDTH - int'(amt)));
            3'b?01:  result = (data << amt) | (data >> (REGS_WIDTH - int'(amt)));
            default: result = data;
        endcase
    end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one barrel_shifter between NREQ requesters,
// with a single registered, id-tagged response stage.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_EMPTY | result register empty, resp_valid=0
//   ST_FULL  | result register holds an unread result, resp_valid=1
module shift_arbiter
    import shift_pkg::*;
#(
    parameter  int REGS_WIDTH = 32,
    parameter  int NREQ       = 2,
    localparam int AW         = $clog2(REGS_WIDTH),
    localparam int IDW        = $clog2(NREQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ*REGS_WIDTH-1:0] req_data,
    input  logic [NREQ*3-1:0]          req_opsel,
    input  logic [NREQ*AW-1:0]         req_amount,
    output logic                       resp_valid,
    output logic [IDW-1:0]             resp_id,
    output logic [REGS_WIDTH-1:0]      resp_data,
    input  logic                       resp_ready
);

    resp_state_t           state, state_next;
    logic [IDW-1:0]        rr_ptr;
    logic [IDW-1:0]        grant_idx;
    logic                  grant_any;
    logic                  stall;
    logic                  accept;
    logic [REGS_WIDTH-1:0] sel_data;
    opcode_t               sel_op;
    logic [AW-1:0]         sel_amt;
    logic [REGS_WIDTH-1:0] shift_res;

    assign stall = resp_valid & ~resp_ready;

    // Scan from the far end back toward rr_ptr so the nearest valid requester wins.
    always_comb begin
        int idx;
        idx       = 0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (req_valid[idx]) begin
                grant_idx = IDW'(idx);
                grant_any = 1'b1;
            end
        end
    end

    assign req_ready = (grant_any & ~stall & ~rst) ? (NREQ'(1) << grant_idx) : '0;
    assign accept    = |(req_valid & req_ready);

    assign sel_data = req_data[grant_idx*REGS_WIDTH +: REGS_WIDTH];
    assign sel_op   = opcode_t'(req_opsel[grant_idx*3 +: 3]);
    assign sel_amt  = req_amount[grant_idx*AW +: AW];

    barrel_shifter #(.REGS_WIDTH(REGS_WIDTH)) u_shifter (
        .data   (sel_data),
        .opsel  (sel_op),
        .amount (sel_amt),
        .result (shift_res)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        resp_valid = (state == ST_FULL);
        case (state)
            ST_EMPTY: if (accept) state_next = ST_FULL;
            ST_FULL:  if (!accept && resp_ready) state_next = ST_EMPTY;
            default:  state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_data <= '0;
            resp_id   <= '0;
            rr_ptr    <= '0;
        end else if (accept) begin
            resp_data <= shift_res;
            resp_id   <= grant_idx;
            rr_ptr    <= IDW'((int'(grant_idx) + 1) % NREQ);
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed and randomized checks of shift_arbiter against a behavioural model
// of grant order, shift results and response-register occupancy.
module tb_shift_arbiter;
    import shift_pkg::*;

    localparam int W   = 32;
    localparam int N   = 2;
    localparam int AW  = 5;
    localparam int IDW = 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_data;
    logic [N*3-1:0]   req_opsel;
    logic [N*AW-1:0]  req_amount;
    logic             resp_valid;
    logic [IDW-1:0]   resp_id;
    logic [W-1:0]     resp_data;
    logic             resp_ready;

    int n_assert = 0;
    int n_fail   = 0;

    bit        m_valid;
    int        m_id;
    logic [W-1:0] m_data;
    int        m_rr;
    int        m_last;

    shift_arbiter #(.REGS_WIDTH(W), .NREQ(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .req_opsel  (req_opsel),
        .req_amount (req_amount),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .resp_ready (resp_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_shift(input logic [2:0] op, input logic [W-1:0] d, input int a_in);
        logic [2*W-1:0] dd;
        logic [W-1:0]   r;
        int             a;
        a  = a_in % W;
        dd = {d, d};
        if (op[2] && op[1]) begin
            r = d >> a;
            if (d[W-1]) r = r | ~({W{1'b1}} >> a);
        end else if (op[1] && op[0]) begin
            dd = dd >> a;
            r  = dd[W-1:0];
        end else if (op[1]) begin
            r = d >> a;
        end else if (op[0]) begin
            dd = dd << a;
            r  = dd[2*W-1:W];
        end else begin
            r = d << a;
        end
        return r;
    endfunction

    function automatic int ref_grant();
        for (int k = 0; k < N; k++) begin
            if (req_valid[(m_rr + k) % N]) return (m_rr + k) % N;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input bit v, input logic [2:0] op, input logic [W-1:0] d, input int a);
        req_valid[i]          = v;
        req_opsel[i*3 +: 3]   = op;
        req_data[i*W +: W]    = d;
        req_amount[i*AW +: AW] = AW'(a);
    endtask

    // One clock: check grant before the edge, advance the model, check the response after.
    task automatic step();
        int           g;
        logic [N-1:0] exp_ready;
        #1;
        if (rst || (m_valid && !resp_ready)) g = -1;
        else g = ref_grant();
        exp_ready = (g >= 0) ? (N'(1) << g) : '0;
        chk("req_ready", 64'(req_ready), 64'(exp_ready));
        m_last = g;
        if (rst) begin
            m_valid = 0; m_id = 0; m_data = '0; m_rr = 0;
        end else if (g >= 0) begin
            m_data  = ref_shift(req_opsel[g*3 +: 3], req_data[g*W +: W], int'(req_amount[g*AW +: AW]));
            m_id    = g;
            m_valid = 1;
            m_rr    = (g + 1) % N;
        end else if (resp_ready) begin
            m_valid = 0;
        end
        @(posedge clk);
        #1;
        chk("resp_valid", 64'(resp_valid), 64'(m_valid));
        chk("resp_id", 64'(resp_id), 64'(m_id));
        chk("resp_data", 64'(resp_data), 64'(m_data));
    endtask

    logic [2:0]   ops  [5];
    logic [W-1:0] exp4 [5];
    logic [W-1:0] saved;

    initial begin
        ops  = '{OP_LSL, OP_LSR, OP_ASR, OP_ROR, OP_ROL};
        exp4 = '{32'h0000_00F0, 32'h0F00_0000, 32'hFF00_0000, 32'hFF00_0000, 32'h0000_00FF};
        m_valid = 0; m_id = 0; m_data = '0; m_rr = 0; m_last = -1;
        rst = 1'b1; resp_ready = 1'b1;
        req_valid = '0; req_data = '0; req_opsel = '0; req_amount = '0;
        set_req(0, 1, OP_LSL, 32'h1234_5678, 3);
        step();
        step();
        chk("reset_valid", 64'(resp_valid), 64'd0);
        chk("reset_data", 64'(resp_data), 64'd0);
        rst = 1'b0;
        set_req(0, 0, OP_LSL, '0, 0);
        step();

        // Single request, one-cycle latency
        set_req(0, 1, OP_LSL, 32'h0000_0001, 4);
        step();
        chk("t1_valid", 64'(resp_valid), 64'd1);
        chk("t1_data", 64'(resp_data), 64'h10);
        chk("t1_id", 64'(resp_id), 64'd0);
        set_req(0, 0, OP_LSL, '0, 0);
        step();

        rst = 1'b1;
        step();
        rst = 1'b0;

        // Strict rotation with both requesters always valid
        set_req(0, 1, OP_ROR, 32'h8000_0001, 1);
        set_req(1, 1, OP_ASR, 32'h8000_0000, 31);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t2_id", 64'(resp_id), 64'(k % 2));
            chk("t2_data", 64'(resp_data), (k % 2) ? 64'hFFFF_FFFF : 64'hC000_0000);
        end

        // Backpressure holds everything; release refills in the same cycle
        resp_ready = 1'b0;
        saved = resp_data;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t3_ready", 64'(req_ready), 64'd0);
            chk("t3_hold", 64'(resp_data), 64'(saved));
        end
        resp_ready = 1'b1;
        step();
        chk("t3_refill_valid", 64'(resp_valid), 64'd1);
        chk("t3_refill_id", 64'(resp_id), 64'd0);
        chk("t3_refill_data", 64'(resp_data), 64'hC000_0000);

        // Opcode sweep, amounts 4 and 0
        set_req(1, 0, OP_LSL, '0, 0);
        for (int k = 0; k < 5; k++) begin
            set_req(0, 1, ops[k], 32'hF000_000F, 4);
            step();
            chk("t4_amt4", 64'(resp_data), 64'(exp4[k]));
            set_req(0, 1, ops[k], 32'hF000_000F, 0);
            step();
            chk("t4_amt0", 64'(resp_data), 64'hF000_000F);
        end

        // Reset while full and stalled
        set_req(0, 1, OP_LSL, 32'h0000_0003, 1);
        set_req(1, 1, OP_LSR, 32'h0000_0300, 8);
        resp_ready = 1'b0;
        step();
        chk("t5_full", 64'(resp_valid), 64'd1);
        rst = 1'b1;
        step();
        chk("t5_cleared", 64'(resp_valid), 64'd0);
        rst = 1'b0;
        resp_ready = 1'b1;
        #1;
        chk("t5_grant0", 64'(req_ready), 64'b01);
        step();
        chk("t5_id0", 64'(resp_id), 64'd0);
        chk("t5_data0", 64'(resp_data), 64'h6);
        set_req(0, 0, OP_LSL, '0, 0);
        step();
        chk("t5_id1", 64'(resp_id), 64'd1);
        chk("t5_data1", 64'(resp_data), 64'h3);

        // Randomized traffic; requesters keep operands stable until granted
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || m_last == i) begin
                    set_req(i, $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
                            $urandom, int'($urandom_range(0, 31)));
                end
            end
            resp_ready = ($urandom_range(0, 3) != 0);
            rst        = ($urandom_range(0, 99) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
